// File: rtl/nn_layer_engine.sv
// Time-multiplexed perceptron layer: one signed MAC shared by N_NEURON neurons of N_IN inputs.
// Parameters and inputs arrive over a byte stream; chained runs feed outputs back as inputs.
module nn_layer_engine #(
  parameter int N_IN     = 4,
  parameter int N_NEURON = 4,
  parameter int DW       = 8,
  parameter int ACC_W    = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [DW-1:0]               data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic                        busy,
  output logic                        done,
  input  logic [$clog2(N_NEURON)-1:0] out_sel,
  output logic [DW-1:0]               data_out,
  output logic [N_NEURON-1:0]         fired
);

  localparam int NW   = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
  localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int KW   = $clog2(N_IN + 2);
  localparam int N_CP = (N_IN < N_NEURON) ? N_IN : N_NEURON;

  localparam logic [KW-1:0] K_BIAS  = KW'(N_IN);
  localparam logic [KW-1:0] K_TH    = KW'(N_IN + 1);
  localparam logic [KW-1:0] K_X_END = KW'(N_IN - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(N_NEURON - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2**DW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_P, S_LOAD_X, S_RUN, S_COPY, S_DONE
  } state_t;

  state_t state, state_next;

  logic signed [DW-1:0] w    [N_NEURON][N_IN];
  logic signed [DW-1:0] bias [N_NEURON];
  logic signed [DW-1:0] th   [N_NEURON];
  logic        [DW-1:0] x    [N_IN];
  logic        [DW-1:0] y    [N_NEURON];

  logic [NW-1:0]            n_cnt;
  logic [KW-1:0]            k_cnt;
  logic [IW-1:0]            k_idx;
  logic signed [ACC_W-1:0]  acc;
  logic take;

  // Handshake: a byte moves on any rising edge where data_valid && data_ready;
  // data_ready is high only in LOAD_P/LOAD_X, so bytes offered elsewhere are dropped.
  assign take  = data_valid && data_ready;
  assign k_idx = k_cnt[IW-1:0];

  logic signed [DW:0]       x_s;
  logic signed [DW-1:0]     w_s;
  logic signed [2*DW:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext, th_ext, acc_base, acc_next, acc_clamp;
  logic reached;

  assign x_s      = {1'b0, x[k_idx]};
  assign w_s      = w[n_cnt][k_idx];
  assign prod     = x_s * w_s;
  assign prod_ext = {{(ACC_W-2*DW-1){prod[2*DW]}}, prod};
  assign bias_ext = {{(ACC_W-DW){bias[n_cnt][DW-1]}}, bias[n_cnt]};
  assign th_ext   = {{(ACC_W-DW){th[n_cnt][DW-1]}}, th[n_cnt]};
  // The first MAC of each neuron starts from the bias instead of the running sum.
  assign acc_base = (k_cnt == '0) ? bias_ext : acc;
  assign acc_next = acc_base + prod_ext;
  assign reached  = (acc >= th_ext);

  always_comb begin
    acc_clamp = acc;
    if (acc < 0)          acc_clamp = '0;
    else if (acc > Y_MAX) acc_clamp = Y_MAX;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    data_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          case (mode)
            2'd0:    state_next = S_LOAD_P;
            2'd1:    state_next = S_LOAD_X;
            2'd2:    state_next = S_RUN;
            default: state_next = S_COPY;
          endcase
        end
      end
      S_LOAD_P: begin
        data_ready = 1'b1;
        if (data_valid && n_cnt == N_LAST && k_cnt == K_TH) state_next = S_DONE;
      end
      S_LOAD_X: begin
        data_ready = 1'b1;
        if (data_valid && k_cnt == K_X_END) state_next = S_DONE;
      end
      S_RUN:  if (n_cnt == N_LAST && k_cnt == K_BIAS) state_next = S_DONE;
      S_COPY: state_next = S_RUN;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < N_NEURON; n++) begin
        for (int i = 0; i < N_IN; i++) w[n][i] <= '0;
        bias[n] <= '0;
        th[n]   <= '0;
        y[n]    <= '0;
      end
      for (int i = 0; i < N_IN; i++) x[i] <= '0;
      fired <= '0;
      acc   <= '0;
      n_cnt <= '0;
      k_cnt <= '0;
    end else begin
      case (state)
        S_LOAD_P: if (take) begin
          if (k_cnt < K_BIAS)       w[n_cnt][k_idx] <= data_in;
          else if (k_cnt == K_BIAS) bias[n_cnt]     <= data_in;
          else                      th[n_cnt]       <= data_in;
          if (k_cnt == K_TH) begin
            k_cnt <= '0;
            n_cnt <= n_cnt + 1'b1;
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
        S_LOAD_X: if (take) begin
          x[k_idx] <= data_in;
          k_cnt    <= k_cnt + 1'b1;
        end
        S_COPY: for (int i = 0; i < N_CP; i++) x[i] <= y[i];
        S_RUN: begin
          if (k_cnt == K_BIAS) begin
            fired[n_cnt] <= reached;
            y[n_cnt]     <= reached ? acc_clamp[DW-1:0] : '0;
            k_cnt        <= '0;
            n_cnt        <= n_cnt + 1'b1;
          end else begin
            acc   <= acc_next;
            k_cnt <= k_cnt + 1'b1;
          end
        end
        default: begin
          k_cnt <= '0;
          n_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    if (32'(out_sel) < N_NEURON) data_out = y[out_sel];
  end

endmodule

// File: tb/tb_nn_layer_engine.sv
// Bench for nn_layer_engine: arithmetic model of the layer plus directed scenarios
// with literal expectations for loads, runs, chaining, saturation, stalls and reset.
module tb_nn_layer_engine;
  localparam int N_IN = 4, N_NEURON = 4, DW = 8, ACC_W = 20;

  logic       clk = 1'b0;
  logic       reset, start, data_valid;
  logic [1:0] mode, out_sel;
  logic [7:0] data_in, data_out;
  logic       data_ready, busy, done;
  logic [3:0] fired;

  always #5 clk = ~clk;

  nn_layer_engine #(.N_IN(N_IN), .N_NEURON(N_NEURON), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .done(done),
    .out_sel(out_sel), .data_out(data_out), .fired(fired)
  );

  int mw [4][4];
  int mb [4], mth [4], mx [4], my [4];
  logic [3:0] mfired;
  bit cmp_en;
  int checks, errors;
  logic [7:0] bq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: whole-layer arithmetic with plain integers.
  function automatic void model_run();
    for (int n = 0; n < 4; n++) begin
      int acc;
      acc = mb[n];
      for (int i = 0; i < 4; i++) acc += mx[i] * mw[n][i];
      mfired[n] = (acc >= mth[n]);
      if (!mfired[n])     my[n] = 0;
      else if (acc < 0)   my[n] = 0;
      else if (acc > 255) my[n] = 255;
      else                my[n] = acc;
    end
  endfunction

  function automatic void model_clear();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++) mw[n][i] = 0;
      mb[n] = 0; mth[n] = 0; mx[n] = 0; my[n] = 0;
    end
    mfired = '0;
  endfunction

  function automatic void set_neuron(int n, int w0, int w1, int w2, int w3, int b, int t);
    mw[n][0] = w0; mw[n][1] = w1; mw[n][2] = w2; mw[n][3] = w3;
    mb[n] = b; mth[n] = t;
  endfunction

  // Outputs are stable in IDLE; check them every cycle while the model is current.
  always @(posedge clk) begin
    #4;
    if (cmp_en) begin
      chk("idle_data_out", data_out, my[out_sel]);
      chk("idle_fired", fired, mfired);
      chk("idle_busy", busy, 0);
      chk("idle_ready", data_ready, 0);
      chk("idle_done", done, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      out_sel = out_sel + 1'b1;
    end
  endtask

  task automatic read_y(input int n, input int exp, input string name);
    @(negedge clk);
    out_sel = 2'(n);
    #1 chk(name, data_out, exp);
  endtask

  task automatic run_cmd(input logic [1:0] m, input int exp_cycles, input bit poke);
    int cycles;
    @(negedge clk);
    cmp_en = 1'b0; start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 100) begin
      if (poke && cycles == 5) begin start = 1'b1; mode = 2'd0; end
      else start = 1'b0;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    chk(m == 2'd3 ? "chain_latency" : "run_latency", cycles, exp_cycles);
    if (m == 2'd3)
      for (int i = 0; i < 4; i++) mx[i] = my[i];
    model_run();
    @(negedge clk);
    chk("done_pulse", done, 0);
    cmp_en = 1'b1;
  endtask

  task automatic load_cmd(input logic [1:0] m, input int gap_at);
    int last;
    @(negedge clk);
    cmp_en = 1'b0; start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0;
    last = bq.size() - 1;
    for (int i = 0; i <= last; i++) begin
      if (i == gap_at) begin
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_busy", busy, 1);
      end
      data_valid = 1'b1;
      data_in = bq[i];
      @(negedge clk);
      chk("load_ready", data_ready, (i < last) ? 1 : 0);
    end
    data_valid = 1'b0;
    chk("load_done", done, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    cmp_en = 1'b1;
  endtask

  task automatic load_params(input int gap_at);
    bq.delete();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++) bq.push_back(8'(mw[n][i]));
      bq.push_back(8'(mb[n]));
      bq.push_back(8'(mth[n]));
    end
    load_cmd(2'd0, gap_at);
  endtask

  task automatic load_x();
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(8'(mx[i]));
    load_cmd(2'd1, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    checks = 0; errors = 0; cmp_en = 1'b0;
    reset = 1'b1; start = 1'b0; mode = 2'd0; data_in = 8'h00; data_valid = 1'b0; out_sel = 2'd0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_fired", fired, 0);
    chk("reset_done", done, 0);
    chk("reset_data_out", data_out, 0);
    reset = 1'b0;
    cmp_en = 1'b1;
    idle(4);

    // Zero parameters: acc=0 meets th=0, so every neuron fires with y=0.
    run_cmd(2'd2, 21, 1'b0);
    chk("zero_fired", fired, 4'b1111);
    read_y(2, 0, "zero_y2");
    idle(4);

    // Scenario 2 with a stall after byte 7; junk offered in IDLE must be dropped.
    set_neuron(0, 1, 1, 1, 1, 0, 10);
    set_neuron(1, -1, -1, -1, -1, 5, 0);
    set_neuron(2, 2, -3, 4, -1, -7, -100);
    set_neuron(3, 10, 20, 30, 40, 0, 100);
    data_valid = 1'b1; data_in = 8'hAA;
    idle(3);
    load_params(7);
    mx = '{3, 3, 3, 3};
    load_x();
    idle(2);
    run_cmd(2'd2, 21, 1'b0);
    read_y(0, 12, "s2_y0");
    read_y(1, 0, "s2_y1");
    read_y(2, 0, "s2_y2");
    read_y(3, 255, "s2_y3");
    #1 chk("s2_fired", fired, 4'b1101);
    idle(4);

    // Chained: x becomes {12,0,0,255}; start during busy must be ignored.
    run_cmd(2'd3, 22, 1'b1);
    read_y(0, 255, "ch_y0");
    read_y(3, 255, "ch_y3");
    #1 chk("ch_fired", fired, 4'b1001);
    idle(4);

    // Saturation, then the far negative corner and threshold-equality boundaries.
    for (int n = 0; n < 4; n++) set_neuron(n, 127, 127, 127, 127, 127, 0);
    mx = '{255, 255, 255, 255};
    load_params(-1);
    load_x();
    run_cmd(2'd2, 21, 1'b0);
    read_y(1, 255, "sat_y1");
    #1 chk("sat_fired", fired, 4'b1111);
    idle(3);
    set_neuron(0, -128, -128, -128, -128, -128, 127);
    set_neuron(1, 0, 0, 0, 0, 127, 127);
    set_neuron(2, 0, 0, 0, 0, 126, 127);
    set_neuron(3, 127, 127, 127, 127, 127, -128);
    load_params(20);
    run_cmd(2'd2, 21, 1'b0);
    read_y(0, 0, "neg_y0");
    read_y(1, 127, "eq_y1");
    read_y(2, 0, "below_y2");
    #1 chk("edge_fired", fired, 4'b1010);
    idle(3);

    // Reset mid-RUN: abort without done, everything back to zero.
    @(negedge clk);
    cmp_en = 1'b0; start = 1'b1; mode = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_fired", fired, 0);
    reset = 1'b0;
    nd = 0;
    cmp_en = 1'b1;
    repeat (30) begin
      @(negedge clk);
      out_sel = out_sel + 1'b1;
      if (done) nd++;
    end
    chk("rst_no_done", nd, 0);
    run_cmd(2'd2, 21, 1'b0);
    chk("rst_zero_fired", fired, 4'b1111);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
